puf_auth_sequencer: RTL

//  Initiator/verifier side of the RO-PUF challenge/response interface.
//  - Issues a sequence of 6-bit challenges to the RO array core.
//  - Waits for each measurement window to end, then captures the 8-bit response.
//  - ENROLL mode: stores the responses in an internal CRP table.
//  - AUTH mode: compares responses to the table, accumulates Hamming distance
//    and reports pass/fail. Sits between board switches/buttons and the RO core.

---
 rtl/puf_pkg.sv | 24 ++
 rtl/puf_auth_sequencer_popcount8.sv | 15 +
 rtl/puf_auth_sequencer.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/puf_pkg.sv
// Shared types and helpers for the RO-PUF challenge/response sequencer.
package puf_pkg;

    localparam int CHAL_W = 6;
    localparam int RESP_W = 8;

    typedef logic [CHAL_W-1:0] chal_t;
    typedef logic [RESP_W-1:0] resp_t;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_ARM  = 3'd2,
        S_WAIT = 3'd3,
        S_CAPT = 3'd4,
        S_FIN  = 3'd5
    } seq_state_t;

    // Bitwise 2-of-3 vote across repeated measurements of one challenge.
    function automatic resp_t maj3(input resp_t a, input resp_t b, input resp_t c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/puf_auth_sequencer_popcount8.sv
// Combinational population count of an 8-bit word.
module popcount8 (
    input  logic [7:0] bits,
    output logic [3:0] count
);

    // Sum the set bits of the input word.
    always_comb begin
        count = 4'd0;
        for (int k = 0; k < 8; k++) begin
            count = count + {3'd0, bits[k]};
        end
    end

endmodule

// File: rtl/puf_auth_sequencer.sv
// Challenge/response sequencer for the RO-PUF: enrolls a CRP table or authenticates against it.
// Define MAJORITY_VOTE_EN to measure each challenge three times and vote bitwise.
module puf_auth_sequencer
    import puf_pkg::*;
#(
    parameter int N_CHAL      = 16,
    parameter int HD_THRESH   = 8,
    parameter int TIMEOUT_CYC = 100_000_000,
    parameter int SETTLE_CYC  = 4
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        start,
    input  logic        enroll,
    input  logic [5:0]  chal_base,
    output logic [5:0]  challenge,
    output logic        chal_load,
    input  logic        resp_done,
    input  logic [7:0]  response,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        enrolled,
    output logic        timeout_err,
    output logic [9:0]  hd_total
);

    localparam logic [6:0]  N_LAST   = 7'(N_CHAL - 1);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYC - 1);
    localparam logic [31:0] SET_LAST = 32'(SETTLE_CYC - 1);
    localparam logic [31:0] HD_LIM   = 32'(HD_THRESH);

    seq_state_t  state_r;
    logic        enroll_r;
    chal_t       base_r;
    logic [6:0]  idx_r;
    logic [31:0] settle_r;
    logic [31:0] tmo_r;
    resp_t       resp_r;
    resp_t       table_r [64];
    logic [3:0]  pc_s;
    logic [10:0] hd_sum_s;
`ifdef MAJORITY_VOTE_EN
    logic [1:0]  meas_r;
    resp_t       samp0_r;
    resp_t       samp1_r;
`endif

    popcount8 u_popcount (
        .bits  (resp_r ^ table_r[idx_r[5:0]]),
        .count (pc_s)
    );

    assign hd_sum_s = {1'b0, hd_total} + {7'd0, pc_s};

    // CRP table: no reset so contents survive an aborted run (enrolled gates their use).
    always_ff @(posedge CLK) begin
        if (state_r == S_CAPT && enroll_r) begin
            table_r[idx_r[5:0]] <= resp_r;
        end
    end

    // Sequencer FSM with registered outputs.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_r     <= S_IDLE;
            enroll_r    <= 1'b0;
            base_r      <= 6'd0;
            idx_r       <= 7'd0;
            settle_r    <= 32'd0;
            tmo_r       <= 32'd0;
            resp_r      <= 8'd0;
            challenge   <= 6'd0;
            chal_load   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            pass        <= 1'b0;
            enrolled    <= 1'b0;
            timeout_err <= 1'b0;
            hd_total    <= 10'd0;
`ifdef MAJORITY_VOTE_EN
            meas_r      <= 2'd0;
            samp0_r     <= 8'd0;
            samp1_r     <= 8'd0;
`endif
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        enroll_r    <= enroll;
                        base_r      <= chal_base;
                        idx_r       <= 7'd0;
                        pass        <= 1'b0;
                        timeout_err <= 1'b0;
                        hd_total    <= 10'd0;
                        busy        <= 1'b1;
                        challenge   <= chal_base;
                        chal_load   <= 1'b1;
                        settle_r    <= 32'd0;
`ifdef MAJORITY_VOTE_EN
                        meas_r      <= 2'd0;
`endif
                        state_r     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (settle_r == SET_LAST) begin
                        chal_load <= 1'b0;
                        tmo_r     <= 32'd0;
                        state_r   <= S_ARM;
                    end else begin
                        settle_r <= settle_r + 32'd1;
                    end
                end
                // ARM drops the stale done level of the previous window before WAIT trusts it.
                S_ARM, S_WAIT: begin
                    if (state_r == S_ARM && !resp_done) begin
                        tmo_r   <= tmo_r + 32'd1;
                        state_r <= S_WAIT;
                    end else if (state_r == S_WAIT && resp_done) begin
`ifdef MAJORITY_VOTE_EN
                        if (meas_r == 2'd2) begin
                            resp_r  <= maj3(samp0_r, samp1_r, response);
                            meas_r  <= 2'd0;
                            state_r <= S_CAPT;
                        end else begin
                            if (meas_r == 2'd0) begin
                                samp0_r <= response;
                            end else begin
                                samp1_r <= response;
                            end
                            meas_r    <= meas_r + 2'd1;
                            chal_load <= 1'b1;
                            settle_r  <= 32'd0;
                            state_r   <= S_LOAD;
                        end
`else
                        resp_r  <= response;
                        state_r <= S_CAPT;
`endif
                    end else if (tmo_r == TMO_LAST) begin
                        timeout_err <= 1'b1;
                        done        <= 1'b1;
                        pass        <= 1'b0;
                        busy        <= 1'b0;
                        if (enroll_r) begin
                            enrolled <= 1'b0;
                        end
                        state_r     <= S_IDLE;
                    end else begin
                        tmo_r <= tmo_r + 32'd1;
                    end
                end
                S_CAPT: begin
                    if (!enroll_r) begin
                        hd_total <= hd_sum_s[10] ? 10'h3FF : hd_sum_s[9:0];
                    end
                    idx_r <= idx_r + 7'd1;
                    if (idx_r == N_LAST) begin
                        state_r <= S_FIN;
                    end else begin
                        challenge <= base_r + idx_r[5:0] + 6'd1;
                        chal_load <= 1'b1;
                        settle_r  <= 32'd0;
                        state_r   <= S_LOAD;
                    end
                end
                S_FIN: begin
                    done <= 1'b1;
                    busy <= 1'b0;
                    if (enroll_r) begin
                        enrolled <= 1'b1;
                    end else begin
                        pass <= ({22'd0, hd_total} <= HD_LIM) && enrolled;
                    end
                    state_r <= S_IDLE;
                end
                default: begin
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
